// File: rtl/alu_nibble_link.sv
// rtl/alu_nibble_link.sv - nibble-serial add/sub front end with accumulator and valid/ready handshake
module alu_nibble_link #(
  parameter logic [3:0] ACC_INIT = 4'h0,
  parameter logic [7:0] TIMEOUT  = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_A   = 3'd1,
    S_GET_B   = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND_LO = 3'd4,
    S_SEND_HI = 3'd5
  } state_t;

  localparam logic [8:0] TO_LIMIT = {1'b0, TIMEOUT};
  localparam logic       TO_EN    = (TIMEOUT != 8'd0);

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] res_q, res_d;
  logic       sel_q, sel_d;
  logic       mode_q, mode_d;
  logic       clr_q, clr_d;
  logic       flag_q, flag_d;
  logic       zero_q, zero_d;
  logic       err_q, err_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic [3:0] in_nib;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic       accept;
  logic       in_get;
  logic       to_hit;
  logic [3:0] a_sel;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [3:0] exec_r;
  logic       exec_flag;
  logic [3:0] out_nib;

  wire unused_inputs = &{1'b0, ena, uio_in, ui_in[7:6]};

  assign in_nib    = ui_in[3:0];
  assign in_valid  = ui_in[4];
  assign out_ready = ui_in[5];

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
  assign out_valid = (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
  assign accept    = in_valid && in_ready;
  assign in_get    = (state_q == S_GET_A) || (state_q == S_GET_B);
  assign to_hit    = TO_EN && in_get && !accept && (({1'b0, tcnt_q} + 9'd1) == TO_LIMIT);

  // clr is applied only at EXEC so a timed-out frame leaves the accumulator untouched
  assign a_sel     = mode_q ? (clr_q ? ACC_INIT : acc_q) : a_q;
  assign sum       = {1'b0, a_sel} + {1'b0, b_q};
  assign diff      = {1'b0, a_sel} - {1'b0, b_q};
  assign exec_r    = sel_q ? diff[3:0] : sum[3:0];
  assign exec_flag = sel_q ? (a_sel < b_q) : sum[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_INIT;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      res_q   <= 4'h0;
      sel_q   <= 1'b0;
      mode_q  <= 1'b0;
      clr_q   <= 1'b0;
      flag_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      clr_q   <= clr_d;
      flag_q  <= flag_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    clr_d   = clr_q;
    flag_d  = flag_q;
    zero_d  = zero_q;
    err_d   = err_q;
    tcnt_d  = 8'd0;

    if (TO_EN && in_get && !accept && !to_hit) begin
      tcnt_d = tcnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d   = in_nib[0];
          mode_d  = in_nib[1];
          clr_d   = in_nib[2];
          err_d   = 1'b0;
          state_d = in_nib[1] ? S_GET_B : S_GET_A;
        end
      end
      S_GET_A: begin
        if (accept) begin
          a_d     = in_nib;
          state_d = S_GET_B;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GET_B: begin
        if (accept) begin
          b_d     = in_nib;
          state_d = S_EXEC;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        res_d   = exec_r;
        acc_d   = exec_r;
        flag_d  = exec_flag;
        zero_d  = (exec_r == 4'h0);
        state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (out_ready) begin
          state_d = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    out_nib = 4'h0;
    if (state_q == S_SEND_LO) begin
      out_nib = res_q;
    end else if (state_q == S_SEND_HI) begin
      out_nib = {3'b000, flag_q};
    end
  end

  assign uo_out  = {flag_q, zero_q, out_valid, in_ready, out_nib};
  assign uio_out = {err_q, state_q, acc_q};
  assign uio_oe  = 8'hFF;

endmodule
